// File: rtl/wd_ocl_csr.sv
// wd_ocl_csr: AXI4-Lite CSR slave for the OCL BAR.
// Holds N_RW control registers, exposes N_RO status inputs and two ID words.
// Write address and write data are caught in independent one-entry holding
// registers, so AW and W may arrive in any order; a write commits once both
// are present and no write response is outstanding. A beat that arrives in the
// commit cycle itself is used directly, which gives single-cycle write latency.
module wd_ocl_csr #(
    parameter int          ADDR_W   = 32,
    parameter int          N_RW     = 8,
    parameter int          N_RO     = 8,
    parameter logic [31:0] CTRL_RST = 32'h0,
    parameter logic [31:0] ID0      = 32'hF010_1D0F,
    parameter logic [31:0] ID1      = 32'h1D51_FEDC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   s_awaddr,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [31:0]         s_wdata,
    input  logic [3:0]          s_wstrb,
    input  logic                s_wvalid,
    output logic                s_wready,
    output logic [1:0]          s_bresp,
    output logic                s_bvalid,
    input  logic                s_bready,
    input  logic [ADDR_W-1:0]   s_araddr,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [31:0]         s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rvalid,
    input  logic                s_rready,
    output logic [N_RW*32-1:0]  ctrl_o,
    output logic [N_RW-1:0]     ctrl_wr_o,
    input  logic [N_RO*32-1:0]  stat_i
);

    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [1:0]  RESP_SLVERR   = 2'b10;
    localparam logic [31:0] UNMAPPED_DATA = 32'hBAD0_ADD0;

    // Keeps all readies low during reset and for the reset cycle's aftermath,
    // so readies first rise the cycle after rst has been sampled low.
    logic                  ready_block_q;

    logic                  aw_held_q, aw_held_d;
    logic [ADDR_W-1:0]     awaddr_q;
    logic                  w_held_q, w_held_d;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;

    logic                  bvalid_q;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic [N_RW-1:0][31:0] ctrl_q, ctrl_d;
    logic [N_RW-1:0]       ctrl_wr_q, ctrl_wr_d;

    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_W-1:0]     wr_addr;
    logic [31:0]           wr_data;
    logic [3:0]            wr_strb;
    logic [6:0]            wr_idx, rd_idx;
    logic                  wr_in_page, rd_in_page;
    logic                  unused_addr_lsbs;

    assign s_awready = ~aw_held_q & ~ready_block_q;
    assign s_wready  = ~w_held_q & ~ready_block_q;
    assign s_arready = ~rvalid_q & ~ready_block_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign s_rvalid  = rvalid_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;
    assign ctrl_o    = ctrl_q;
    assign ctrl_wr_o = ctrl_wr_q;

    assign aw_hs = s_awvalid & s_awready;
    assign w_hs  = s_wvalid & s_wready;
    assign ar_hs = s_arvalid & s_arready;

    // A beat arriving this cycle is usable immediately, held or not.
    assign wr_addr = aw_held_q ? awaddr_q : s_awaddr;
    assign wr_data = w_held_q ? wdata_q : s_wdata;
    assign wr_strb = w_held_q ? wstrb_q : s_wstrb;

    assign commit    = (aw_held_q | aw_hs) & (w_held_q | w_hs) & ~bvalid_q;
    assign aw_held_d = (aw_held_q | aw_hs) & ~commit;
    assign w_held_d  = (w_held_q | w_hs) & ~commit;

    // Word index within the 512-byte page; anything above bit 8 must be zero.
    assign wr_idx     = wr_addr[8:2];
    assign rd_idx     = s_araddr[8:2];
    assign wr_in_page = (wr_addr[ADDR_W-1:9] == '0);
    assign rd_in_page = (s_araddr[ADDR_W-1:9] == '0);

    assign unused_addr_lsbs = ^{wr_addr[1:0], s_araddr[1:0]};

    // Write decode: only control registers accept writes, merged byte by byte.
    always_comb begin
        ctrl_d    = ctrl_q;
        ctrl_wr_d = '0;
        bresp_d   = RESP_SLVERR;
        for (int i = 0; i < N_RW; i++) begin
            if (wr_in_page && (wr_idx == 7'(i))) begin
                bresp_d = RESP_OKAY;
                if (commit) begin
                    ctrl_wr_d[i] = 1'b1;
                    for (int k = 0; k < 4; k++) begin
                        if (wr_strb[k]) begin
                            ctrl_d[i][8*k +: 8] = wr_data[8*k +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read decode: uses the current (pre-write) control value and live status.
    always_comb begin
        rdata_d = UNMAPPED_DATA;
        rresp_d = RESP_SLVERR;
        if (rd_in_page) begin
            for (int i = 0; i < N_RW; i++) begin
                if (rd_idx == 7'(i)) begin
                    rdata_d = ctrl_q[i];
                    rresp_d = RESP_OKAY;
                end
            end
            for (int j = 0; j < N_RO; j++) begin
                if (rd_idx == 7'(64 + j)) begin
                    rdata_d = stat_i[32*j +: 32];
                    rresp_d = RESP_OKAY;
                end
            end
            if (rd_idx == 7'd126) begin
                rdata_d = ID0;
                rresp_d = RESP_OKAY;
            end
            if (rd_idx == 7'd127) begin
                rdata_d = ID1;
                rresp_d = RESP_OKAY;
            end
        end
    end

    // Control/handshake state: holds, responses and the control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_block_q <= 1'b1;
            aw_held_q     <= 1'b0;
            w_held_q      <= 1'b0;
            bvalid_q      <= 1'b0;
            bresp_q       <= RESP_OKAY;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            rresp_q       <= RESP_OKAY;
            ctrl_q        <= {N_RW{CTRL_RST}};
            ctrl_wr_q     <= '0;
        end else begin
            ready_block_q <= 1'b0;
            aw_held_q     <= aw_held_d;
            w_held_q      <= w_held_d;
            ctrl_q        <= ctrl_d;
            ctrl_wr_q     <= ctrl_wr_d;
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= bresp_d;
            end else if (bvalid_q && s_bready) begin
                bvalid_q <= 1'b0;
            end
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdata_d;
                rresp_q  <= rresp_d;
            end else if (rvalid_q && s_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Payload capture for beats that must wait for their partner.
    always_ff @(posedge clk) begin
        if (aw_hs) begin
            awaddr_q <= s_awaddr;
        end
        if (w_hs) begin
            wdata_q <= s_wdata;
            wstrb_q <= s_wstrb;
        end
    end

endmodule

// File: tb/tb_wd_ocl_csr.sv
// Testbench for wd_ocl_csr: directed scenarios plus a randomized phase, with
// expected responses queued at issue time and checked by a separate monitor.
module tb_wd_ocl_csr;

    localparam int          ADDR_W   = 32;
    localparam int          N_RW     = 8;
    localparam int          N_RO     = 8;
    localparam logic [31:0] CTRL_RST = 32'h0;
    localparam logic [31:0] ID0      = 32'hF010_1D0F;
    localparam logic [31:0] ID1      = 32'h1D51_FEDC;
    localparam logic [31:0] BAD      = 32'hBAD0_ADD0;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [ADDR_W-1:0]   s_awaddr = '0;
    logic                s_awvalid = 1'b0;
    logic                s_awready;
    logic [31:0]         s_wdata = '0;
    logic [3:0]          s_wstrb = '0;
    logic                s_wvalid = 1'b0;
    logic                s_wready;
    logic [1:0]          s_bresp;
    logic                s_bvalid;
    logic                s_bready = 1'b1;
    logic [ADDR_W-1:0]   s_araddr = '0;
    logic                s_arvalid = 1'b0;
    logic                s_arready;
    logic [31:0]         s_rdata;
    logic [1:0]          s_rresp;
    logic                s_rvalid;
    logic                s_rready = 1'b1;
    logic [N_RW*32-1:0]  ctrl_o;
    logic [N_RW-1:0]     ctrl_wr_o;
    logic [N_RO*32-1:0]  stat_i = '0;

    wd_ocl_csr #(
        .ADDR_W(ADDR_W), .N_RW(N_RW), .N_RO(N_RO),
        .CTRL_RST(CTRL_RST), .ID0(ID0), .ID1(ID1)
    ) dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .ctrl_o(ctrl_o), .ctrl_wr_o(ctrl_wr_o), .stat_i(stat_i)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] resp; logic [N_RW-1:0] pulse; } bExp_t;
    typedef struct { logic [31:0] data; logic [1:0] resp; } rExp_t;

    bExp_t       bQueue[$];
    rExp_t       rQueue[$];
    logic [31:0] ctrlModel[N_RW];
    logic [31:0] statModel[N_RO];
    int          checks = 0;
    int          errors = 0;
    int          bReadyMode = 1;
    int          rReadyMode = 1;
    logic        bSeen = 1'b0;

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Reference model: byte-address view of the register map.
    function automatic rExp_t modelRead(input logic [31:0] addr);
        rExp_t e;
        int    off;
        e.data = BAD;
        e.resp = 2'b10;
        off = int'(addr & 32'h1FC);
        if (addr < 32'h200) begin
            if (off < 4 * N_RW) begin
                e.data = ctrlModel[off / 4];
                e.resp = 2'b00;
            end else if (off >= 'h100 && off < 'h100 + 4 * N_RO) begin
                e.data = statModel[(off - 'h100) / 4];
                e.resp = 2'b00;
            end else if (off == 'h1F8) begin
                e.data = ID0;
                e.resp = 2'b00;
            end else if (off == 'h1FC) begin
                e.data = ID1;
                e.resp = 2'b00;
            end
        end
        return e;
    endfunction

    function automatic bExp_t modelWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bExp_t       b;
        int          idx;
        logic [31:0] mask;
        b.resp  = 2'b10;
        b.pulse = '0;
        idx = int'(addr & 32'h1FC) / 4;
        if (addr < 32'h200 && idx < N_RW) begin
            mask = '0;
            for (int k = 0; k < 4; k++) if (strb[k]) mask = mask | (32'hFF << (8 * k));
            ctrlModel[idx] = (ctrlModel[idx] & ~mask) | (data & mask);
            b.resp  = 2'b00;
            b.pulse = N_RW'(1) << idx;
        end
        return b;
    endfunction

    function automatic logic [N_RW*32-1:0] modelCtrl();
        logic [N_RW*32-1:0] v;
        for (int i = 0; i < N_RW; i++) v[32*i +: 32] = ctrlModel[i];
        return v;
    endfunction

    task automatic driveStat();
        for (int j = 0; j < N_RO; j++) stat_i[32*j +: 32] = statModel[j];
    endtask

    task automatic resetModel();
        for (int i = 0; i < N_RW; i++) ctrlModel[i] = CTRL_RST;
        bQueue.delete();
        rQueue.delete();
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sendAw(input logic [31:0] addr);
        bit done;
        done = 0;
        s_awaddr = addr;
        s_awvalid = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            done = s_awready;
            cycle();
        end
        s_awvalid = 1'b0;
        checks++;
        if (!done) begin errors++; $display("[TB] FAIL aw_timeout: no awready for addr %0h", addr); end
    endtask

    task automatic sendW(input logic [31:0] data, input logic [3:0] strb);
        bit done;
        done = 0;
        s_wdata = data;
        s_wstrb = strb;
        s_wvalid = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            done = s_wready;
            cycle();
        end
        s_wvalid = 1'b0;
        checks++;
        if (!done) begin errors++; $display("[TB] FAIL w_timeout: no wready for data %0h", data); end
    endtask

    task automatic sendAr(input logic [31:0] addr);
        bit done;
        done = 0;
        s_araddr = addr;
        s_arvalid = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            done = s_arready;
            cycle();
        end
        s_arvalid = 1'b0;
        checks++;
        if (!done) begin errors++; $display("[TB] FAIL ar_timeout: no arready for addr %0h", addr); end
    endtask

    task automatic issueWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                              input int awDelay, input int wDelay);
        bQueue.push_back(modelWrite(addr, data, strb));
        fork
            begin
                repeat (awDelay) cycle();
                sendAw(addr);
            end
            begin
                repeat (wDelay) cycle();
                sendW(data, strb);
            end
        join
    endtask

    task automatic issueRead(input logic [31:0] addr);
        rQueue.push_back(modelRead(addr));
        sendAr(addr);
    endtask

    task automatic waitResponses();
        int n;
        n = 0;
        while ((bQueue.size() != 0 || rQueue.size() != 0) && n < 300) begin
            cycle();
            n++;
        end
        checks++;
        if (bQueue.size() != 0 || rQueue.size() != 0) begin
            errors++;
            $display("[TB] FAIL resp_timeout: pending b %0d r %0d", bQueue.size(), rQueue.size());
            bQueue.delete();
            rQueue.delete();
        end
    endtask

    task automatic checkCtrl(input string name);
        checkOutput(name, 256'(ctrl_o), 256'(modelCtrl()));
    endtask

    // Randomized serial traffic over mapped, read-only, ID and unmapped space.
    task automatic applyStimulus(input int nTxn);
        logic [31:0] addr;
        bReadyMode = 2;
        rReadyMode = 2;
        for (int t = 0; t < nTxn; t++) begin
            for (int j = 0; j < N_RO; j++) statModel[j] = $urandom;
            driveStat();
            case ($urandom_range(0, 4))
                0:       addr = 32'(4 * $urandom_range(0, N_RW - 1)) | 32'($urandom_range(0, 3));
                1:       addr = 32'h100 + 32'(4 * $urandom_range(0, 63));
                2:       addr = $urandom_range(0, 1) ? 32'h1F8 : 32'h1FC;
                3:       addr = 32'($urandom_range(0, 511));
                default: addr = (32'h1 << $urandom_range(9, 31)) | 32'($urandom_range(0, 511));
            endcase
            if ($urandom_range(0, 1) == 1) begin
                issueWrite(addr, $urandom, 4'($urandom_range(0, 15)),
                           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end else begin
                issueRead(addr);
            end
            waitResponses();
            checkCtrl("rand_ctrl_o");
        end
        bReadyMode = 1;
        rReadyMode = 1;
    endtask

    // Response-channel readies: low, high or random, changed just after the edge.
    always begin
        cycle();
        s_bready = (bReadyMode == 2) ? 1'($urandom_range(0, 1)) : (bReadyMode == 1);
        s_rready = (rReadyMode == 2) ? 1'($urandom_range(0, 1)) : (rReadyMode == 1);
    end

    // Monitor: pops the scoreboard on every completed B/R handshake.
    always @(negedge clk) begin
        bExp_t be;
        rExp_t re;
        if (rst) begin
            bSeen = 1'b0;
        end else begin
            if (s_bvalid && !bSeen) begin
                if (bQueue.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_b: bresp %0h with nothing outstanding", s_bresp);
                end else begin
                    checkOutput("ctrl_wr_pulse", 256'(ctrl_wr_o), 256'(bQueue[0].pulse));
                end
            end else begin
                checkOutput("ctrl_wr_idle", 256'(ctrl_wr_o), 256'(0));
            end
            if (s_bvalid && s_bready && bQueue.size() != 0) begin
                be = bQueue.pop_front();
                checkOutput("bresp", 256'(s_bresp), 256'(be.resp));
            end
            bSeen = s_bvalid && !s_bready;
            if (s_rvalid && s_rready) begin
                if (rQueue.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_r: rdata %0h with nothing outstanding", s_rdata);
                end else begin
                    re = rQueue.pop_front();
                    checkOutput("rdata", 256'(s_rdata), 256'(re.data));
                    checkOutput("rresp", 256'(s_rresp), 256'(re.resp));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rExp_t              re;
        bExp_t              be;
        logic [N_RW*32-1:0] snap;

        resetModel();
        for (int j = 0; j < N_RO; j++) statModel[j] = 32'h5000_0000 + 32'(j);
        driveStat();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_awready", 256'(s_awready), 256'(0));
        checkOutput("rst_wready", 256'(s_wready), 256'(0));
        checkOutput("rst_arready", 256'(s_arready), 256'(0));
        checkOutput("rst_bvalid", 256'(s_bvalid), 256'(0));
        checkOutput("rst_rvalid", 256'(s_rvalid), 256'(0));
        checkOutput("rst_rdata", 256'({s_rdata, s_rresp, s_bresp}), 256'(0));
        checkOutput("rst_ctrl_wr", 256'(ctrl_wr_o), 256'(0));
        checkCtrl("rst_ctrl_o");
        cycle();
        rst = 1'b0;
        cycle();
        @(negedge clk);
        checkOutput("post_rst_readies", 256'({s_awready, s_wready, s_arready}), 256'(3'b111));
        cycle();

        // Same-cycle AW and W: response one cycle after the handshake
        issueWrite(32'h000, 32'hA5A5_1234, 4'hF, 0, 0);
        checkOutput("t1_bvalid_latency", 256'(s_bvalid), 256'(1));
        checkOutput("t1_pulse", 256'(ctrl_wr_o), 256'(1));
        waitResponses();
        checkOutput("t1_ctrl0", 256'(ctrl_o[31:0]), 256'(32'hA5A5_1234));
        issueRead(32'h000);
        waitResponses();

        // W three cycles ahead of AW, partial strobes
        bQueue.push_back(modelWrite(32'h004, 32'hFFFF_FFFF, 4'h5));
        sendW(32'hFFFF_FFFF, 4'h5);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checkOutput("t2_wready_held", 256'(s_wready), 256'(0));
            checkOutput("t2_no_early_b", 256'(s_bvalid), 256'(0));
            cycle();
        end
        sendAw(32'h004);
        waitResponses();
        checkOutput("t2_ctrl1", 256'(ctrl_o[63:32]), 256'(32'h00FF_00FF));
        checkCtrl("t2_ctrl_o");

        // ID words and a status register
        statModel[0] = 32'h1357;
        driveStat();
        issueRead(32'h1F8);
        waitResponses();
        issueRead(32'h1FC);
        waitResponses();
        issueRead(32'h100);
        waitResponses();

        // Read-only write and unmapped read
        issueWrite(32'h100, 32'hDEAD_BEEF, 4'hF, 0, 1);
        waitResponses();
        issueRead(32'h180);
        waitResponses();
        checkCtrl("t4_ctrl_o");

        // Back-pressure on both response channels
        bReadyMode = 0;
        rReadyMode = 0;
        repeat (2) cycle();
        issueWrite(32'h008, 32'h1111_2222, 4'hF, 0, 0);
        snap = modelCtrl();
        issueWrite(32'h00C, 32'h3333_4444, 4'hF, 1, 0);
        issueRead(32'h104);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            checkOutput("bp_b", 256'({s_bvalid, s_bresp}), 256'(3'b100));
            checkOutput("bp_r", 256'({s_rvalid, s_rresp, s_rdata}), 256'({1'b1, 2'b00, statModel[1]}));
            checkOutput("bp_readies", 256'({s_awready, s_wready, s_arready}), 256'(0));
            checkOutput("bp_no_commit", 256'(ctrl_o), 256'(snap));
            cycle();
        end
        bReadyMode = 1;
        rReadyMode = 1;
        waitResponses();
        checkCtrl("bp_ctrl_o");

        // Same-cycle read and write to one register: read sees the old value
        re = modelRead(32'h00C);
        rQueue.push_back(re);
        be = modelWrite(32'h00C, 32'h5555_6666, 4'hF);
        bQueue.push_back(be);
        fork
            sendAw(32'h00C);
            sendW(32'h5555_6666, 4'hF);
            sendAr(32'h00C);
        join
        waitResponses();
        checkCtrl("rw_ctrl_o");

        // Reset while a response is outstanding and a W beat is held
        bReadyMode = 0;
        repeat (2) cycle();
        issueWrite(32'h010, 32'h7777_8888, 4'hF, 0, 0);
        sendW(32'h9999_AAAA, 4'hF);
        rst = 1'b1;
        cycle();
        @(negedge clk);
        checkOutput("midrst_bvalid", 256'(s_bvalid), 256'(0));
        checkOutput("midrst_ctrl_o", 256'(ctrl_o), 256'({N_RW{CTRL_RST}}));
        resetModel();
        bReadyMode = 1;
        cycle();
        rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            checkOutput("midrst_no_late_b", 256'(s_bvalid), 256'(0));
            cycle();
        end
        issueWrite(32'h014, 32'hCAFE_F00D, 4'h3, 2, 0);
        waitResponses();
        checkCtrl("midrst_ctrl_o_after");
        issueRead(32'h014);
        waitResponses();

        applyStimulus(150);

        repeat (4) cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
